// File: rtl/fetch_queue_if.sv
// Fetch-queue port bundle: the fetch-side capture, the decode-side handshake
// and the flush/overflow control, all grouped into one interface.
// master = the environment that drives fetch/decode/flush,
// slave  = the queue itself.
interface fetch_queue_if #(
  parameter int PC_W = 64
);
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            in_valid;
  logic            fetch_busy;
  logic            fetch_stall;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic            out_valid;
  logic            out_ready;
  logic            flush;
  logic            overflow;

  modport master (
    output in_instr, in_pc, in_valid, fetch_busy, out_ready, flush,
    input  fetch_stall, out_instr, out_pc, out_valid, overflow
  );

  modport slave (
    input  in_instr, in_pc, in_valid, fetch_busy, out_ready, flush,
    output fetch_stall, out_instr, out_pc, out_valid, overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {instr, pc} pairs captured from one-cycle
// fetch pulses and hands them to decode over a valid/ready handshake.
// A redirect flush empties the queue and can arm a one-shot discard of a
// stale response still in flight.
// Optional feature macro: FETCHQ_BYPASS_EN (zero-latency pass-through when
// the queue is empty). Without it there is no path from in_* to out_*.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.slave   fq
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   STALL_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          drop_next_reg;
  logic          overflow_reg;

  logic head_valid;
  logic full;
  logic accept;
  logic out_valid_c;
  logic pop_req;
  logic push_req;
  logic bypass_take;
  logic push;
  logic pop;
  logic drop;

  assign head_valid = (count_reg != '0);
  assign full       = (count_reg == FULL_CNT);
  // An incoming pulse is a candidate entry unless flushed or marked stale.
  assign accept     = fq.in_valid & ~fq.flush & ~drop_next_reg;

`ifdef FETCHQ_BYPASS_EN
  logic bypass_hit;
  // Empty queue: present the incoming pulse straight to decode.
  assign bypass_hit  = accept & ~head_valid;
  assign bypass_take = bypass_hit & fq.out_ready;
  assign out_valid_c = head_valid | bypass_hit;

  // Head data, falling back to the live input when bypassing.
  always_comb begin
    fq.out_instr = '0;
    fq.out_pc    = '0;
    if (head_valid) begin
      fq.out_instr = instr_mem[rd_ptr_reg];
      fq.out_pc    = pc_mem[rd_ptr_reg];
    end else if (bypass_hit) begin
      fq.out_instr = fq.in_instr;
      fq.out_pc    = fq.in_pc;
    end
  end
`else
  assign bypass_take = 1'b0;
  assign out_valid_c = head_valid;

  // Head data, forced to zero when the queue is empty.
  always_comb begin
    fq.out_instr = '0;
    fq.out_pc    = '0;
    if (head_valid) begin
      fq.out_instr = instr_mem[rd_ptr_reg];
      fq.out_pc    = pc_mem[rd_ptr_reg];
    end
  end
`endif

  assign pop_req  = out_valid_c & fq.out_ready & ~fq.flush;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_req = accept & (~full | pop_req);
  // A bypassed entry that decode consumes never touches storage.
  assign push     = push_req & ~bypass_take;
  assign pop      = pop_req & ~bypass_take;
  assign drop     = accept & full & ~pop_req;

  assign fq.out_valid   = out_valid_c;
  // Leave one slot free for the single response that may still be in flight.
  assign fq.fetch_stall = (count_reg >= STALL_CNT);
  assign fq.overflow    = overflow_reg;

  // Entry storage: written on push only, no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem[wr_ptr_reg] <= fq.in_instr;
      pc_mem[wr_ptr_reg]    <= fq.in_pc;
    end
  end

  // Pointer, occupancy, stale-drop and sticky overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      drop_next_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (fq.flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      // Stale response still owed if upstream is busy and it did not land now.
      drop_next_reg <= fq.fetch_busy & ~fq.in_valid;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
      if (drop_next_reg && fq.in_valid) drop_next_reg <= 1'b0;
      if (drop) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, PC_W=64).
// Build with FETCHQ_BYPASS_EN defined to exercise the bypass step.
module tb_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fetch_queue_if #(.PC_W(64)) fq ();

  fetch_queue #(.DEPTH(4), .PC_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push1(input logic [63:0] pc, input logic [31:0] instr);
    fq.in_pc    = pc;
    fq.in_instr = instr;
    fq.in_valid = 1'b1;
    step();
    fq.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fq.in_instr   = '0;
    fq.in_pc      = '0;
    fq.in_valid   = 1'b0;
    fq.fetch_busy = 1'b0;
    fq.out_ready  = 1'b0;
    fq.flush      = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 64'(fq.out_valid), 64'd0);
    chk("rst_stall", 64'(fq.fetch_stall), 64'd0);
    chk("rst_instr", 64'(fq.out_instr), 64'd0);
    chk("rst_pc", fq.out_pc, 64'd0);
    chk("rst_ovf", 64'(fq.overflow), 64'd0);

    // Single push, one-cycle latency, held with out_ready=0
    push1(64'h8000_0000, 32'h0000_0413);
    chk("p1_valid", 64'(fq.out_valid), 64'd1);
    chk("p1_pc", fq.out_pc, 64'h8000_0000);
    chk("p1_instr", 64'(fq.out_instr), 64'h0000_0413);
    chk("p1_stall", 64'(fq.fetch_stall), 64'd0);
    step();
    chk("p1_hold_valid", 64'(fq.out_valid), 64'd1);
    chk("p1_hold_pc", fq.out_pc, 64'h8000_0000);

    // Fill to DEPTH, stall from count 3, fifth pulse overflows
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push1(64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i));
      chk("fill_stall", 64'(fq.fetch_stall), (i >= 2) ? 64'd1 : 64'd0);
    end
    push1(64'h8000_0010, 32'h104);
    chk("ovf_set", 64'(fq.overflow), 64'd1);
    chk("ovf_head", fq.out_pc, 64'h8000_0000);
    fq.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(fq.out_valid), 64'd1);
      chk("drain_pc", fq.out_pc, 64'h8000_0000 + 64'(4 * i));
      chk("drain_instr", 64'(fq.out_instr), 64'h100 + 64'(i));
      step();
    end
    chk("drained_valid", 64'(fq.out_valid), 64'd0);
    chk("drained_pc", fq.out_pc, 64'd0);
    chk("ovf_sticky", 64'(fq.overflow), 64'd1);
    step();  // empty with out_ready=1
    chk("empty_rdy_vld", 64'(fq.out_valid), 64'd0);
    chk("empty_rdy_stl", 64'(fq.fetch_stall), 64'd0);
    fq.out_ready = 1'b0;

    // Full queue: simultaneous push and pop
    do_reset();
    chk("ovf_cleared", 64'(fq.overflow), 64'd0);
    for (int i = 0; i < 4; i++) push1(64'h8000_0000 + 64'(4 * i), 32'h200 + 32'(i));
    fq.out_ready = 1'b1;
    push1(64'h8000_0010, 32'h204);
    fq.out_ready = 1'b0;
    chk("full_pp_ovf", 64'(fq.overflow), 64'd0);
    chk("full_pp_head", fq.out_pc, 64'h8000_0004);
    chk("full_pp_stall", 64'(fq.fetch_stall), 64'd1);
    fq.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("pp_drain_pc", fq.out_pc, 64'h8000_0000 + 64'(4 * i));
      chk("pp_drain_in", 64'(fq.out_instr), 64'h200 + 64'(i));
      step();
    end
    chk("pp_empty", 64'(fq.out_valid), 64'd0);
    fq.out_ready = 1'b0;

    // Flush with busy upstream: next pulse is stale and discarded
    push1(64'h8000_0100, 32'h300);
    push1(64'h8000_0104, 32'h301);
    fq.fetch_busy = 1'b1;
    fq.flush = 1'b1;
    step();
    fq.flush = 1'b0;
    chk("fl_valid", 64'(fq.out_valid), 64'd0);
    chk("fl_stall", 64'(fq.fetch_stall), 64'd0);
    push1(64'h8000_0008, 32'h302);
    chk("stale_drop", 64'(fq.out_valid), 64'd0);
    chk("stale_noovf", 64'(fq.overflow), 64'd0);
    push1(64'h8000_1000, 32'h303);
    fq.fetch_busy = 1'b0;
    chk("after_vld", 64'(fq.out_valid), 64'd1);
    chk("after_pc", fq.out_pc, 64'h8000_1000);
    chk("after_instr", 64'(fq.out_instr), 64'h303);
    fq.out_ready = 1'b1;
    step();
    fq.out_ready = 1'b0;
    chk("after_empty", 64'(fq.out_valid), 64'd0);

    // Flush coinciding with the response: nothing left to drop
    fq.fetch_busy = 1'b1;
    fq.flush = 1'b1;
    push1(64'h8000_2000, 32'h400);
    fq.flush = 1'b0;
    fq.fetch_busy = 1'b0;
    chk("flin_valid", 64'(fq.out_valid), 64'd0);
    push1(64'h8000_3000, 32'h401);
    chk("flin_next_v", 64'(fq.out_valid), 64'd1);
    chk("flin_next_pc", fq.out_pc, 64'h8000_3000);

    // Flush with idle upstream: following pulse accepted
    fq.flush = 1'b1;
    step();
    fq.flush = 1'b0;
    chk("flidle_vld", 64'(fq.out_valid), 64'd0);
    push1(64'h8000_5000, 32'h500);
    chk("flidle_pc", fq.out_pc, 64'h8000_5000);
    fq.out_ready = 1'b1;
    step();
    fq.out_ready = 1'b0;

    // Empty queue, pulse with out_ready=1 in the same cycle
    fq.in_pc    = 64'h8000_0020;
    fq.in_instr = 32'h600;
    fq.in_valid = 1'b1;
    fq.out_ready = 1'b1;
    #1;
`ifdef FETCHQ_BYPASS_EN
    chk("byp_valid", 64'(fq.out_valid), 64'd1);
    chk("byp_pc", fq.out_pc, 64'h8000_0020);
    chk("byp_instr", 64'(fq.out_instr), 64'h600);
    step();
    fq.in_valid = 1'b0;
    fq.out_ready = 1'b0;
    chk("byp_consumed", 64'(fq.out_valid), 64'd0);
`else
    chk("nobyp_valid", 64'(fq.out_valid), 64'd0);
    chk("nobyp_pc", fq.out_pc, 64'd0);
    step();
    fq.in_valid = 1'b0;
    fq.out_ready = 1'b0;
    chk("nobyp_next_v", 64'(fq.out_valid), 64'd1);
    chk("nobyp_next_pc", fq.out_pc, 64'h8000_0020);
`endif

    // Reset mid-stream discards everything
    push1(64'h8000_7000, 32'h700);
    do_reset();
    chk("midrst_valid", 64'(fq.out_valid), 64'd0);
    chk("midrst_pc", fq.out_pc, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
